nes_controller_port: RTL

- Emulates the NES standard controller on CPU registers $4016/$4017, fed by the USB HID keycode exported from the SoC (`keycode`, 8 bits, single key, 0x00 = none).
- Decodes the keycode into the 8-button vector and debounces it with a stability filter.
- Implements the strobe/latch/serial-shift protocol the 6502 sees.
- Sits on the CPU bus inside NES_ARCHITECUTRE, alongside PPU/APU register decode; the CPU data mux consumes its read data.

---
 rtl/nes_controller_port_pkg.sv | 46 ++++
 rtl/nes_controller_port_if.sv | 12 +
 rtl/nes_controller_port_key_filter.sv | 42 ++++
 rtl/nes_controller_port.sv | 74 +++++++
 4 files changed

// File: rtl/nes_controller_port_pkg.sv
// Shared constants for the NES controller port: HID keycodes, button bit
// positions, register addresses and the keycode-to-button decode.
package nes_ctrl_pkg;

    localparam logic [7:0] KC_K     = 8'h0E;
    localparam logic [7:0] KC_J     = 8'h0D;
    localparam logic [7:0] KC_BKSP  = 8'h2A;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [15:0] REG_PORT0 = 16'h4016;
    localparam logic [15:0] REG_PORT1 = 16'h4017;

    // Upper bits the NES returns on controller reads (open-bus residue).
    localparam logic [7:0] OPEN_BUS = 8'h40;

    function automatic logic [7:0] decode_key(input logic [7:0] kc);
        logic [7:0] btn;
        btn = '0;
        case (kc)
            KC_K:     btn[BTN_A]      = 1'b1;
            KC_J:     btn[BTN_B]      = 1'b1;
            KC_BKSP:  btn[BTN_SELECT] = 1'b1;
            KC_ENTER: btn[BTN_START]  = 1'b1;
            KC_W:     btn[BTN_UP]     = 1'b1;
            KC_S:     btn[BTN_DOWN]   = 1'b1;
            KC_A:     btn[BTN_LEFT]   = 1'b1;
            KC_D:     btn[BTN_RIGHT]  = 1'b1;
            default:  btn = '0;
        endcase
        return btn;
    endfunction

endpackage

// File: rtl/nes_controller_port_if.sv
// CPU-side register bus seen by the controller port.
interface nes_controller_port_if;
    logic        ENABLE;
    logic [15:0] ADDR;
    logic        CPU_RW_n;
    logic [7:0]  DIN;
    logic [7:0]  DOUT;
    logic        DOUT_oe;

    modport master (output ENABLE, ADDR, CPU_RW_n, DIN, input DOUT, DOUT_oe);
    modport slave  (input ENABLE, ADDR, CPU_RW_n, DIN, output DOUT, DOUT_oe);
endinterface

// File: rtl/nes_controller_port_key_filter.sv
// Registers the asynchronous keycode, decodes it, and accepts a button vector
// only after it has been stable for STABLE_CYCLES consecutive cycles.
module nes_key_filter
    import nes_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic       CPU_CLK,
    input  logic       RESET_n,
    input  logic [7:0] controller_keycode,
    output logic [7:0] buttons
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [7:0]    keycode_q;
    logic [7:0]    decoded;
    logic [7:0]    cand;
    logic [CW-1:0] cnt;

    assign decoded = decode_key(keycode_q);

    // cnt saturates at CNT_LAST so a long-held key keeps buttons asserted.
    always_ff @(posedge CPU_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            keycode_q <= '0;
            cand      <= '0;
            cnt       <= '0;
            buttons   <= '0;
        end else begin
            keycode_q <= controller_keycode;
            if (decoded != cand) begin
                cand <= decoded;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                buttons <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/nes_controller_port.sv
// NES standard controller on $4016/$4017: strobe latch, serial shift register
// and read-data mux for the CPU bus.
module nes_controller_port
    import nes_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic [15:0] PORT0_ADDR    = REG_PORT0,
    parameter logic [15:0] PORT1_ADDR    = REG_PORT1
) (
    input  logic                 CPU_CLK,
    input  logic                 RESET_n,
    input  logic [7:0]           controller_keycode,
    nes_controller_port_if.slave bus,
    output logic [7:0]           buttons_dbg,
    output logic                 strobe_dbg
);
    logic [7:0] buttons;
    logic [7:0] shift_reg;
    logic       strobe;
    logic       rd_hit_q;
    logic       port0_sel, port1_sel;
    logic       wr_hit, rd_hit, rd_edge;
    logic       unused_din;

    nes_key_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .CPU_CLK            (CPU_CLK),
        .RESET_n            (RESET_n),
        .controller_keycode (controller_keycode),
        .buttons            (buttons)
    );

    assign port0_sel  = (bus.ADDR == PORT0_ADDR);
    assign port1_sel  = (bus.ADDR == PORT1_ADDR);
    assign wr_hit     = bus.ENABLE & ~bus.CPU_RW_n & port0_sel;
    assign rd_hit     = bus.ENABLE &  bus.CPU_RW_n & port0_sel;
    assign rd_edge    = rd_hit & ~rd_hit_q;
    assign unused_din = ^bus.DIN[7:1];

    // A read held on the bus shifts once: only its first cycle is an edge.
    always_ff @(posedge CPU_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            strobe    <= 1'b0;
            shift_reg <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            rd_hit_q <= rd_hit;
            if (wr_hit)
                strobe <= bus.DIN[0];
            if (bus.ENABLE) begin
                if (strobe)
                    shift_reg <= buttons;
                else if (rd_edge)
                    shift_reg <= {1'b1, shift_reg[7:1]};
            end
        end
    end

    always_comb begin
        bus.DOUT    = '0;
        bus.DOUT_oe = 1'b0;
        if (RESET_n && bus.ENABLE && bus.CPU_RW_n) begin
            if (port0_sel) begin
                bus.DOUT_oe = 1'b1;
                bus.DOUT    = {OPEN_BUS[7:1], strobe ? buttons[0] : shift_reg[0]};
            end else if (port1_sel) begin
                bus.DOUT_oe = 1'b1;
                bus.DOUT    = OPEN_BUS;
            end
        end
    end

    assign buttons_dbg = buttons;
    assign strobe_dbg  = strobe;
endmodule
